// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready flow control, optional skid entry,
// synchronous flush and write-back value select.
module mem_wb_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 4,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] mem_data_in,
   input  logic              mem_r_en_in,
   input  logic              wb_en_in,
   input  logic [DEST_W-1:0] dest_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_res,
   output logic [DATA_W-1:0] data_mem,
   output logic              mem_r_en,
   output logic              wb_en,
   output logic [DEST_W-1:0] wb_dst,
   output logic [DATA_W-1:0] wb_value,
   output logic [1:0]        occupancy
);

   localparam int ENT_W = 2 * DATA_W + 2 + DEST_W;

   logic             r_h_v;
   logic             r_s_v;
   logic [ENT_W-1:0] r_h;
   logic [ENT_W-1:0] r_s;

   logic             w_accept;
   logic             w_pop;
   logic [ENT_W-1:0] w_in;
   logic             w_h_ld;
   logic             w_h_wb;

   assign w_in = {alu_res_in, mem_data_in, mem_r_en_in, wb_en_in, dest_in};

   // Skid mode: ready depends only on the skid flop, never on out_ready.
   assign in_ready = (SKID != 0) ? !r_s_v : (!r_h_v || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_pop    = r_h_v && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h_v <= 1'b0;
         r_s_v <= 1'b0;
         r_h   <= '0;
         r_s   <= '0;
      end else if (flush) begin
         r_h_v <= 1'b0;
         r_s_v <= 1'b0;
      end else if (SKID == 0) begin
         if (w_accept) begin
            r_h   <= w_in;
            r_h_v <= 1'b1;
         end else if (w_pop) begin
            r_h_v <= 1'b0;
         end
      end else begin
         if (w_pop && r_s_v) begin
            r_h   <= r_s;
            r_h_v <= 1'b1;
            r_s_v <= 1'b0;
         end else if (w_pop) begin
            r_h_v <= w_accept;
            if (w_accept) begin
               r_h <= w_in;
            end
         end else if (w_accept) begin
            if (r_h_v) begin
               r_s   <= w_in;
               r_s_v <= 1'b1;
            end else begin
               r_h   <= w_in;
               r_h_v <= 1'b1;
            end
         end
      end
   end

   assign {alu_res, data_mem, w_h_ld, w_h_wb, wb_dst} = r_h;

   assign mem_r_en  = w_h_ld;
   assign out_valid = r_h_v;
   assign wb_en     = w_h_wb && r_h_v;
   assign wb_value  = w_h_ld ? data_mem : alu_res;
   assign occupancy = {1'b0, r_h_v} + {1'b0, r_s_v};

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
Parametrised MEM→WB pipeline stage with valid/ready flow control, optional 2-entry skid buffer, synchronous flush and built-in write-back select. It sits between data-memory access and register-file write-back. It lets the back end stall without losing in-flight instructions, and it presents a single resolved write-back value to the register file and forwarding unit.

Parameters:
DATA_W, 32, width of ALU result, memory data and write-back value
DEST_W, 4, width of destination register index
SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  MEM stage presents an entry
in_ready  output  1  stage accepts an entry this cycle
alu_res_in  input  DATA_W  ALU result from MEM stage
mem_data_in  input  DATA_W  data-memory read output
mem_r_en_in  input  1  entry is a load
wb_en_in  input  1  entry writes the register file
dest_in  input  DEST_W  destination register index
out_valid  output  1  head entry valid
out_ready  input  1  WB consumer accepts head entry
alu_res  output  DATA_W  head entry ALU result
data_mem  output  DATA_W  head entry memory data
mem_r_en  output  1  head entry load flag
wb_en  output  1  head wb_en_in AND out_valid
wb_dst  output  DEST_W  head destination index
wb_value  output  DATA_W  mem_r_en ? data_mem : alu_res (combinational from head)
occupancy  output  2  number of valid entries (0..2; max 1 when SKID=0)

Behaviour:
- Reset (async, rst=1): both entries invalid, all held fields 0. Outputs: out_valid=0, wb_en=0, alu_res=data_mem=wb_value=0, wb_dst=0, mem_r_en=0, occupancy=0, in_ready=1.
- Accept = in_valid & in_ready; pop = out_valid & out_ready. Latency: an entry accepted at edge N is visible on the outputs after edge N when the stage was empty.
- SKID=1 entries: head (H) and skid (S). in_ready = !S.valid, registered, with no combinational path from out_ready.
  - Empty + accept → H.
  - H valid, no pop, accept → S.
  - Pop, S valid → H←S. S is then refilled by a same-cycle accept only if S was empty (it was not), so in_ready=0 is never violated.
  - Pop, S empty, accept → H←input.
  - Pop, no accept → H invalid.
  - Order is strictly FIFO.
- SKID=0: H only. in_ready = !H.valid | out_ready (combinational). Accept with pop replaces H in the same edge.
- flush=1 at an edge: H.valid=S.valid=0. A same-cycle accept is dropped. A same-cycle pop is still counted as consumed by the consumer. Data fields keep stale values, but wb_en reads 0 because of valid gating. in_ready=1 next cycle.
- flush has priority over accept and over internal moves. rst has priority over everything.
- wb_en is never 1 while out_valid=0. Bubbles never write the register file.
- Held outputs stay stable while out_valid=1 and out_ready=0, even with in_valid toggling.
- occupancy = H.valid + S.valid, updated on the same edge as the valid bits.
- Reset asserted mid-transfer clears immediately without waiting for clk. The first accept after rst deasserts behaves as from empty.

Test Plan:
- Reset: rst=1 with random inputs → all outputs 0, in_ready=1, occupancy=0. Deassert, present alu=0x11, wb_en=1, dest=3, out_ready=1 → one cycle later out_valid=1, wb_value=0x11, wb_dst=3, wb_en=1.
- Load select: mem_r_en_in=1, alu=0xAAAA0000, mem=0x12345678 → wb_value=0x12345678. Same entry with mem_r_en_in=0 → wb_value=0xAAAA0000.
- Skid fill (SKID=1): out_ready=0, push A=0x1 then B=0x2 → occupancy=2, in_ready=0, head still A. Set out_ready=1 → A popped, then B, then out_valid=0. No loss or duplication.
- Stream: in_valid=1 and out_ready=1 for 8 cycles with values 0..7 → outputs 0..7 in order, one per cycle, in_ready held at 1.
- Flush: occupancy=2, assert flush with in_valid=1 (C=0x3) → next cycle out_valid=0, wb_en=0, occupancy=0, in_ready=1. C never appears on the outputs.
- SKID=0 variant: head valid, out_ready=1, in_valid=1 → in_ready=1 combinationally and head replaced on the same edge. With out_ready=0 → in_ready=0.
